gpi_debounce_sync: RTL and testbench

//  Conditions raw board inputs (buttons, switches, header pins) before they reach gp_i of ibex_demo_system.
//  Per bit: synchroniser chain, then a debounce counter FSM. Outputs a clean level plus 1-cycle edge pulses.

---
 rtl/gpi_debounce_sync.sv | 154 +++++++++++++++
 tb/tb_gpi_debounce_sync.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gpi_debounce_sync.sv
// gpi_debounce_sync
//   Conditions raw board inputs (buttons, switches, header pins) in the clk_sys
//   domain before they reach gp_i of the demo system. Each bit runs through a
//   SyncStages-deep synchroniser and then its own debounce FSM. The block
//   produces a clean level (gp_o) and single-cycle rise/fall pulses.
//
//   Optional feature macro: GPI_DEBOUNCE_IRQ_EN
//     defined   : sticky per-bit change flags (changed_o) with write-one-to-clear
//                 (clr_i), and irq_o as the OR of the flags.
//     undefined : changed_o = '0, irq_o = 0, clr_i ignored, no flag flops.
//   The port list is the same in both builds.

module gpi_debounce_sync #(
    parameter int unsigned      Width          = 5,
    parameter int unsigned      SyncStages     = 2,
    parameter int unsigned      DebounceCycles = 50000,
    parameter logic [Width-1:0] ResetVal       = '0
) (
    input  logic             clk_sys_i,
    input  logic             rst_sys_ni,
    input  logic [Width-1:0] gp_raw_i,
    output logic [Width-1:0] gp_o,
    output logic [Width-1:0] rise_o,
    output logic [Width-1:0] fall_o,
    input  logic [Width-1:0] clr_i,
    output logic [Width-1:0] changed_o,
    output logic             irq_o
);

    // Counter is just wide enough to hold DebounceCycles, so it never wraps:
    // it is cleared as soon as it reaches the terminal value.
    localparam int unsigned      CntW   = $clog2(DebounceCycles + 1);
    localparam logic [CntW-1:0]  CntMax = CntW'(DebounceCycles);
    localparam logic [CntW-1:0]  CntOne = CntW'(1);

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_COUNTING = 1'b1
    } state_e;

    logic [Width-1:0] sync_r [SyncStages];
    logic [Width-1:0] sync_q_s;
    logic [Width-1:0] gp_r;
    logic [Width-1:0] rise_r;
    logic [Width-1:0] fall_r;

    // Plain flop chain on the raw pins; nothing sits between the stages.
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            for (int s = 0; s < SyncStages; s++) begin
                sync_r[s] <= ResetVal;
            end
        end else begin
            sync_r[0] <= gp_raw_i;
            for (int s = 1; s < SyncStages; s++) begin
                sync_r[s] <= sync_r[s-1];
            end
        end
    end

    assign sync_q_s = sync_r[SyncStages-1];

    for (genvar i = 0; i < Width; i++) begin : g_bit
        state_e          state_r;
        logic [CntW-1:0] cnt_r;
        logic            gp_bit_r;
        logic            rise_bit_r;
        logic            fall_bit_r;

        // Debounce FSM: the synced level must disagree with gp_o for
        // DebounceCycles+1 consecutive cycles before gp_o follows it.
        always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
            if (!rst_sys_ni) begin
                state_r    <= ST_STABLE;
                cnt_r      <= '0;
                gp_bit_r   <= ResetVal[i];
                rise_bit_r <= 1'b0;
                fall_bit_r <= 1'b0;
            end else begin
                case (state_r)
                    ST_STABLE: begin
                        rise_bit_r <= 1'b0;
                        fall_bit_r <= 1'b0;
                        if (sync_q_s[i] != gp_bit_r) begin
                            state_r <= ST_COUNTING;
                            cnt_r   <= CntOne;
                        end else begin
                            cnt_r   <= '0;
                        end
                    end
                    ST_COUNTING: begin
                        if (sync_q_s[i] == gp_bit_r) begin
                            // Glitch: input went back before qualifying.
                            state_r    <= ST_STABLE;
                            cnt_r      <= '0;
                            rise_bit_r <= 1'b0;
                            fall_bit_r <= 1'b0;
                        end else if (cnt_r == CntMax) begin
                            // Qualified: the edge pulse appears in the same
                            // cycle that gp_o takes its new value.
                            state_r    <= ST_STABLE;
                            cnt_r      <= '0;
                            gp_bit_r   <= sync_q_s[i];
                            rise_bit_r <= sync_q_s[i];
                            fall_bit_r <= ~sync_q_s[i];
                        end else begin
                            cnt_r      <= cnt_r + CntOne;
                            rise_bit_r <= 1'b0;
                            fall_bit_r <= 1'b0;
                        end
                    end
                    default: begin
                        state_r    <= ST_STABLE;
                        cnt_r      <= '0;
                        rise_bit_r <= 1'b0;
                        fall_bit_r <= 1'b0;
                    end
                endcase
            end
        end

        assign gp_r[i]   = gp_bit_r;
        assign rise_r[i] = rise_bit_r;
        assign fall_r[i] = fall_bit_r;
    end

    assign gp_o   = gp_r;
    assign rise_o = rise_r;
    assign fall_o = fall_r;

`ifdef GPI_DEBOUNCE_IRQ_EN
    logic [Width-1:0] changed_r;

    // Sticky change flags: set by a registered edge pulse, cleared by clr_i;
    // a set in the same cycle as a clear keeps the flag high.
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            changed_r <= '0;
        end else begin
            changed_r <= (changed_r & ~clr_i) | rise_r | fall_r;
        end
    end

    assign changed_o = changed_r;
    assign irq_o     = |changed_r;
`else
    logic unused_clr_s;

    assign unused_clr_s = ^clr_i;
    assign changed_o    = '0;
    assign irq_o        = 1'b0;
`endif

endmodule

// File: tb/tb_gpi_debounce_sync.sv
// Directed testbench for gpi_debounce_sync with Width=5, SyncStages=2,
// DebounceCycles=4, ResetVal=0. Qualification latency is 2+4+1 = 7 cycles.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.

module tb_gpi_debounce_sync;

    logic       clk_sys = 1'b0;
    logic       rst_n   = 1'b0;
    logic [4:0] raw     = 5'b00000;
    logic [4:0] clr     = 5'b00000;
    logic [4:0] gp;
    logic [4:0] rise;
    logic [4:0] fall;
    logic [4:0] changed;
    logic       irq;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk_sys = ~clk_sys;

    gpi_debounce_sync #(
        .Width          (5),
        .SyncStages     (2),
        .DebounceCycles (4),
        .ResetVal       (5'b00000)
    ) dut (
        .clk_sys_i  (clk_sys),
        .rst_sys_ni (rst_n),
        .gp_raw_i   (raw),
        .gp_o       (gp),
        .rise_o     (rise),
        .fall_o     (fall),
        .clr_i      (clr),
        .changed_o  (changed),
        .irq_o      (irq)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    // Holds reset for two edges with the given raw value, releases just after an edge.
    task automatic apply_reset(input logic [4:0] r);
        raw   = r;
        clr   = 5'b00000;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        apply_reset(5'b10101);
        n_chk++;
        if ({gp, rise, fall, changed, irq} !== 21'd0)
            $display("FAIL reset_state: got %b expected %b", {gp, rise, fall, changed, irq}, 21'd0);
        else n_pass++;
        tick(6);
        n_chk++;
        if ({gp, rise, fall} !== 15'd0)
            $display("FAIL reset_cycle6: got %b expected %b", {gp, rise, fall}, 15'd0);
        else n_pass++;
        tick(1);
        n_chk++;
        if ({gp, rise, fall} !== {5'b10101, 5'b10101, 5'b00000})
            $display("FAIL reset_cycle7: got %b expected %b", {gp, rise, fall}, {5'b10101, 5'b10101, 5'b00000});
        else n_pass++;
        tick(1);
        n_chk++;
        if ({gp, rise, fall} !== {5'b10101, 5'b00000, 5'b00000})
            $display("FAIL reset_cycle8: got %b expected %b", {gp, rise, fall}, {5'b10101, 5'b00000, 5'b00000});
        else n_pass++;
    endtask

    task automatic test_glitch;
        int errs;
        apply_reset(5'b00000);
        raw = 5'b00001;
        tick(3);
        raw  = 5'b00000;
        errs = 0;
        for (int c = 0; c < 12; c++) begin
            tick(1);
            n_chk++;
            if ({gp, rise, fall} !== 15'd0) begin
                $display("FAIL glitch_c%0d: got %b expected %b", c, {gp, rise, fall}, 15'd0);
                errs++;
            end else n_pass++;
        end
    endtask

    task automatic test_rise_fall;
        apply_reset(5'b00000);
        raw = 5'b00010;
        tick(6);
        n_chk++;
        if ({gp, rise, fall} !== 15'd0)
            $display("FAIL rise_cycle6: got %b expected %b", {gp, rise, fall}, 15'd0);
        else n_pass++;
        tick(1);
        n_chk++;
        if ({gp, rise, fall} !== {5'b00010, 5'b00010, 5'b00000})
            $display("FAIL rise_cycle7: got %b expected %b", {gp, rise, fall}, {5'b00010, 5'b00010, 5'b00000});
        else n_pass++;
        tick(1);
        n_chk++;
        if ({gp, rise, fall} !== {5'b00010, 5'b00000, 5'b00000})
            $display("FAIL rise_cycle8: got %b expected %b", {gp, rise, fall}, {5'b00010, 5'b00000, 5'b00000});
        else n_pass++;
        raw = 5'b00000;
        tick(6);
        n_chk++;
        if ({gp, rise, fall} !== {5'b00010, 5'b00000, 5'b00000})
            $display("FAIL fall_cycle6: got %b expected %b", {gp, rise, fall}, {5'b00010, 5'b00000, 5'b00000});
        else n_pass++;
        tick(1);
        n_chk++;
        if ({gp, rise, fall} !== {5'b00000, 5'b00000, 5'b00010})
            $display("FAIL fall_cycle7: got %b expected %b", {gp, rise, fall}, {5'b00000, 5'b00000, 5'b00010});
        else n_pass++;
        tick(1);
        n_chk++;
        if ({gp, rise, fall} !== 15'd0)
            $display("FAIL fall_cycle8: got %b expected %b", {gp, rise, fall}, 15'd0);
        else n_pass++;
    endtask

    task automatic test_bounce;
        apply_reset(5'b00000);
        for (int c = 0; c < 20; c++) begin
            raw[3] = ((c % 4) < 2) ? 1'b1 : 1'b0;
            tick(1);
            n_chk++;
            if ({gp, rise, fall} !== 15'd0)
                $display("FAIL bounce_c%0d: got %b expected %b", c, {gp, rise, fall}, 15'd0);
            else n_pass++;
        end
        raw[3] = 1'b1;
        tick(6);
        n_chk++;
        if ({gp, rise, fall} !== 15'd0)
            $display("FAIL bounce_hold6: got %b expected %b", {gp, rise, fall}, 15'd0);
        else n_pass++;
        tick(1);
        n_chk++;
        if ({gp, rise, fall} !== {5'b01000, 5'b01000, 5'b00000})
            $display("FAIL bounce_hold7: got %b expected %b", {gp, rise, fall}, {5'b01000, 5'b01000, 5'b00000});
        else n_pass++;
        for (int c = 0; c < 4; c++) begin
            tick(1);
            n_chk++;
            if ({gp, rise, fall} !== {5'b01000, 5'b00000, 5'b00000})
                $display("FAIL bounce_after_c%0d: got %b expected %b", c, {gp, rise, fall}, {5'b01000, 5'b00000, 5'b00000});
            else n_pass++;
        end
    endtask

    task automatic test_reset_midcount;
        apply_reset(5'b00000);
        raw = 5'b00001;
        tick(7);
        n_chk++;
        if ({gp, rise, fall} !== {5'b00001, 5'b00001, 5'b00000})
            $display("FAIL midrst_pre: got %b expected %b", {gp, rise, fall}, {5'b00001, 5'b00001, 5'b00000});
        else n_pass++;
        raw = 5'b10001;
        tick(3);
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({gp, rise, fall, changed, irq} !== 21'd0)
            $display("FAIL midrst_async: got %b expected %b", {gp, rise, fall, changed, irq}, 21'd0);
        else n_pass++;
        @(posedge clk_sys);
        #1;
        rst_n = 1'b1;
        n_chk++;
        if ({gp, rise, fall} !== 15'd0)
            $display("FAIL midrst_release: got %b expected %b", {gp, rise, fall}, 15'd0);
        else n_pass++;
        tick(6);
        n_chk++;
        if ({gp, rise, fall} !== 15'd0)
            $display("FAIL midrst_cycle6: got %b expected %b", {gp, rise, fall}, 15'd0);
        else n_pass++;
        tick(1);
        n_chk++;
        if ({gp, rise, fall} !== {5'b10001, 5'b10001, 5'b00000})
            $display("FAIL midrst_cycle7: got %b expected %b", {gp, rise, fall}, {5'b10001, 5'b10001, 5'b00000});
        else n_pass++;
    endtask

    task automatic test_irq;
        apply_reset(5'b00000);
        raw = 5'b00100;
        tick(7);
        n_chk++;
        if ({rise, changed, irq} !== {5'b00100, 5'b00000, 1'b0})
            $display("FAIL irq_rise_pulse: got %b expected %b", {rise, changed, irq}, {5'b00100, 5'b00000, 1'b0});
        else n_pass++;
        tick(1);
`ifdef GPI_DEBOUNCE_IRQ_EN
        n_chk++;
        if ({changed, irq} !== {5'b00100, 1'b1})
            $display("FAIL irq_set: got %b expected %b", {changed, irq}, {5'b00100, 1'b1});
        else n_pass++;
`else
        n_chk++;
        if ({changed, irq} !== 6'd0)
            $display("FAIL irq_off_set: got %b expected %b", {changed, irq}, 6'd0);
        else n_pass++;
`endif
        clr = 5'b00100;
        tick(1);
        clr = 5'b00000;
        n_chk++;
        if ({changed, irq} !== 6'd0)
            $display("FAIL irq_clear: got %b expected %b", {changed, irq}, 6'd0);
        else n_pass++;
        raw = 5'b00000;
        tick(7);
        n_chk++;
        if ({fall, changed} !== {5'b00100, 5'b00000})
            $display("FAIL irq_fall_pulse: got %b expected %b", {fall, changed}, {5'b00100, 5'b00000});
        else n_pass++;
        clr = 5'b00100;
        tick(1);
        clr = 5'b00000;
`ifdef GPI_DEBOUNCE_IRQ_EN
        n_chk++;
        if ({changed, irq} !== {5'b00100, 1'b1})
            $display("FAIL irq_set_wins: got %b expected %b", {changed, irq}, {5'b00100, 1'b1});
        else n_pass++;
`else
        n_chk++;
        if ({changed, irq} !== 6'd0)
            $display("FAIL irq_off_set_wins: got %b expected %b", {changed, irq}, 6'd0);
        else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_rise_fall();
        test_bounce();
        test_reset_midcount();
        test_irq();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
